// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU data widths and the fetch FSM state encoding
package cpu_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_INSTR_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch bus; master = fetch stage (mem_req*/mem_addr out, mem_resp* in, instr_* to decoder), slave = memory + decoder side
interface instruction_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
);
  logic mem_req_valid;
  logic mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_resp_valid;
  logic [INSTR_WIDTH-1:0] mem_resp_data;
  logic instr_valid;
  logic instr_ready;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_addr;
  modport master (
    output mem_req_valid, mem_addr, instr_valid, instr_data, instr_addr,
    input mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
  );
  modport slave (
    input mem_req_valid, mem_addr, instr_valid, instr_data, instr_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous first-word-fall-through FIFO; clk/rst, clear empties it, push/din write, pop/dout read, count/full/empty status
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage; clk/rst, pc_value in, pc_increment out, flush in, bus = memory read port + decoder handshake
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_increment,
  input  logic                  flush,
  instruction_fetch_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = ADDR_WIDTH + INSTR_WIDTH;
  fetch_state_t state, next_state;
  logic [ADDR_WIDTH-1:0] tag;
  logic [AW:0] count;
  logic [AW+1:0] occupancy;
  logic [W-1:0] dout;
  logic full, empty, req_fire, push, pop;
  // an outstanding request reserves a FIFO slot so its response always fits
  assign occupancy = {1'b0, count} + (AW+2)'(state != IDLE);
  assign bus.mem_req_valid = !rst && !flush && !full && occupancy < (AW+2)'(DEPTH) && (state == IDLE || bus.mem_resp_valid);
  assign bus.mem_addr = pc_value;
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign pc_increment = req_fire;
  assign push = state == WAIT && bus.mem_resp_valid && !flush;
  assign bus.instr_valid = !empty;
  assign pop = bus.instr_valid && bus.instr_ready;
  assign {bus.instr_addr, bus.instr_data} = dout;
  always_comb begin
    next_state = state;
    next_state = (state == IDLE || bus.mem_resp_valid) ? (req_fire ? WAIT : IDLE) : flush ? DISCARD : state;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : next_state;
    if (req_fire) tag <= pc_value;
  end
  fetch_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .push(push),
    .din({tag, bus.mem_resp_data}),
    .pop(pop),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus randomized run against a stream-level fetch model
module tb_instruction_fetch;
  localparam int DEPTH = 2;
  logic clk, rst, flush, pc_increment;
  logic [7:0] pc_value;
  instruction_fetch_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();
  instruction_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .pc_value(pc_value),
    .pc_increment(pc_increment),
    .flush(flush),
    .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic rst, rdy, resp, ir, fl;
    logic [7:0] npc;
    int rv, inc, iv, ia, ma;
  } vec_t;
  int checks = 0, errors = 0;
  logic [7:0] pc = 8'h00, last_acc = 8'h00;
  vec_t vecs[$];
  // memory model state for the randomized phase
  logic pending = 0, stale = 0;
  int cnt = 0, buf_n = 0, deliveries = 0;
  logic [7:0] paddr = 8'h00, exp_addr = 8'h00;
  function automatic logic [15:0] word(input logic [7:0] a);
    return {a ^ 8'h5a, ~a};
  endfunction
  function automatic vec_t mk(input logic r, rdy, resp, ir, fl, input logic [7:0] npc, input int rv, inc, iv, ia, ma);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.resp = resp; v.ir = ir; v.fl = fl; v.npc = npc;
    v.rv = rv; v.inc = inc; v.iv = iv; v.ia = ia; v.ma = ma;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    logic fire, inc_s;
    logic [7:0] a;
    rst = v.rst; flush = v.fl; pc_value = pc;
    bus.mem_req_ready = v.rdy; bus.mem_resp_valid = v.resp;
    bus.mem_resp_data = word(last_acc); bus.instr_ready = v.ir;
    @(negedge clk);
    if (v.rv >= 0) chk($sformatf("v%0d req_valid", idx), 32'(bus.mem_req_valid), v.rv);
    if (v.inc >= 0) chk($sformatf("v%0d pc_increment", idx), 32'(pc_increment), v.inc);
    if (v.iv >= 0) chk($sformatf("v%0d instr_valid", idx), 32'(bus.instr_valid), v.iv);
    if (v.ia >= 0) begin
      chk($sformatf("v%0d instr_addr", idx), 32'(bus.instr_addr), v.ia);
      chk($sformatf("v%0d instr_data", idx), 32'(bus.instr_data), 32'(word(8'(v.ia))));
    end
    if (v.ma >= 0) chk($sformatf("v%0d mem_addr", idx), 32'(bus.mem_addr), v.ma);
    fire = bus.mem_req_valid && bus.mem_req_ready;
    inc_s = pc_increment;
    a = bus.mem_addr;
    @(posedge clk); #1;
    pc = (v.fl || v.rst) ? v.npc : pc + 8'(inc_s);
    if (fire) last_acc = a;
  endtask
  task automatic mcycle(input int p_rdy, p_ir, p_fl, lat_lo, lat_hi);
    logic rdy, ir, fl, resp, exp_rv, fire, deliv, live;
    logic [7:0] npc;
    rdy = $urandom_range(0, 99) < p_rdy;
    ir = $urandom_range(0, 99) < p_ir;
    fl = $urandom_range(0, 99) < p_fl;
    npc = 8'($urandom_range(0, 255));
    resp = pending && cnt == 0;
    rst = 0; flush = fl; pc_value = pc;
    bus.mem_req_ready = rdy; bus.mem_resp_valid = resp;
    bus.mem_resp_data = word(paddr); bus.instr_ready = ir;
    @(negedge clk);
    exp_rv = !fl && (!pending || resp) && (buf_n + int'(pending) < DEPTH);
    chk("m_req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("m_mem_addr", 32'(bus.mem_addr), 32'(pc));
    fire = exp_rv && rdy;
    chk("m_pc_increment", 32'(pc_increment), 32'(fire));
    chk("m_instr_valid", 32'(bus.instr_valid), 32'(buf_n != 0));
    deliv = buf_n != 0 && ir;
    if (deliv) begin
      chk("m_instr_addr", 32'(bus.instr_addr), 32'(exp_addr));
      chk("m_instr_data", 32'(bus.instr_data), 32'(word(exp_addr)));
      deliveries++;
    end
    @(posedge clk); #1;
    live = resp && !stale && !fl;
    if (deliv) exp_addr++;
    buf_n = fl ? 0 : buf_n + int'(live) - int'(deliv);
    if (resp) stale = 0;
    else if (fl && pending) stale = 1;
    if (fire) begin
      pending = 1;
      cnt = $urandom_range(lat_lo, lat_hi) - 1;
      paddr = pc;
    end else if (resp) pending = 0;
    else if (pending) cnt--;
    if (fl) begin
      pc = npc;
      exp_addr = npc;
    end else pc = pc + 8'(fire);
  endtask
  task automatic model_reset(input logic [7:0] start);
    rst = 1; flush = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.instr_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    pc = start; exp_addr = start;
    pending = 0; stale = 0; cnt = 0; buf_n = 0; deliveries = 0;
  endtask
  initial begin
    rst = 1; flush = 0; pc_value = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0; bus.instr_ready = 0;
    //                 rst rdy rsp ir fl npc     rv inc iv  ia     ma
    vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00,   0, 0, -1, -1, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   1, 1, 0, -1, 'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 8'h00,   1, 1, 0, -1, 'h01));
    vecs.push_back(mk(0, 1, 1, 1, 0, 8'h00,   0, 0, 1, 'h00, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   1, 1, 1, 'h01, 'h02));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00,   1, 1, 0, -1, 'h03));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00,   0, 0, 1, 'h02, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00,   0, 0, 1, 'h02, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00,   0, 0, 1, 'h02, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   0, 0, 1, 'h02, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   1, 1, 1, 'h03, 'h04));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00,   1, 0, 0, -1, 'h05));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   1, 1, 1, 'h04, 'h05));
    vecs.push_back(mk(0, 1, 0, 1, 1, 8'h40,   0, 0, 0, -1, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   0, 0, 0, -1, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 8'h00,   1, 1, 0, -1, 'h40));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00,   1, 0, 0, -1, 'h41));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00,   1, 1, 1, 'h40, 'h41));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00,   0, 0, 1, 'h40, -1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00,   0, 0, 1, 'h40, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00,   1, 1, 1, 'h41, 'h42));
    vecs.push_back(mk(0, 1, 1, 0, 1, 8'h80,   0, 0, 1, 'h41, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00,   1, 1, 0, -1, 'h80));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00,   1, 0, 0, -1, 'h81));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00,   1, 0, 1, 'h80, 'h81));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00,   1, 1, 0, -1, 'h81));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00,   1, 1, 0, -1, 'h82));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h90,   0, 0, -1, -1, -1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00,   1, 0, 0, -1, 'h90));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00,   1, 0, 0, -1, 'h90));
    @(posedge clk); #1;
    foreach (vecs[i]) apply(vecs[i], i);
    model_reset(8'h10);
    for (int i = 0; i < 12; i++) mcycle(100, 100, 0, 3, 3);
    chk("lat3_delivered", 32'(deliveries >= 3), 1);
    model_reset(8'h00);
    for (int i = 0; i < 3000; i++) mcycle(70, 70, 4, 1, 3);
    chk("random_progress", 32'(deliveries > 150), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
